// File: rtl/filter_line_sequencer.sv
// filter_line_sequencer
// Streaming front/back end for the 3x3 line-buffer filter stage. Raster RGB565
// pixels are written line by line into the filter's row RAMs (one unbroken
// write-enable pulse per line), then the read cursor is swept across the line
// and each filtered pixel is handed downstream on a valid/ready stream.
// Optional build macro FILTER_SEQ_STATS_EN adds the stall_cycles counter port.
module filter_line_sequencer #(
  parameter int BLOCK_LENGTH = 240,
  parameter int ROWS         = 240,
  parameter int HOLD         = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        frame_start,
  input  logic [15:0] s_data,
  input  logic        s_valid,
  output logic        s_ready,
  output logic [15:0] m_data,
  output logic        m_valid,
  input  logic        m_ready,
  output logic        m_last,
  output logic [15:0] f_d_in,
  output logic        f_wren,
  output logic [9:0]  f_cursor,
  input  logic [15:0] f_d_out,
  input  logic        f_d_rdy,
  output logic        busy,
  output logic        frame_done
`ifdef FILTER_SEQ_STATS_EN
  ,
  output logic [31:0] stall_cycles
`endif
);

  localparam int ROW_W  = $clog2(ROWS + 1);
  localparam int HOLD_W = $clog2(HOLD + 2);

  localparam logic [9:0]        LAST_COL   = 10'(BLOCK_LENGTH - 1);
  localparam logic [ROW_W-1:0]  LAST_ROW   = ROW_W'(ROWS);
  // row_in value while the third line of a frame is being written
  localparam logic [ROW_W-1:0]  PRIME_LAST = ROW_W'(2);
  localparam logic [HOLD_W-1:0] HOLD_C     = HOLD_W'(HOLD);

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    SETTLE,
    READ,
    EMIT
  } state_t;

  state_t              r_state;
  logic [9:0]          r_col;
  logic [ROW_W-1:0]    r_row_in;
  logic [HOLD_W-1:0]   r_hold;
  logic                r_to_read;   // SETTLE destination: 1 = READ, 0 = WRITE

  logic                r_s_ready;
  logic [15:0]         r_m_data;
  logic                r_m_valid;
  logic                r_m_last;
  logic [15:0]         r_d_in;
  logic                r_wren;
  logic [9:0]          r_cursor;
  logic                r_busy;
  logic                r_frame_done;

  logic w_s_accept;
  logic w_line_end;
  logic w_edge_col;
  logic w_hold_done;
  logic w_primed;
  logic w_more_rows;

  assign w_s_accept  = r_s_ready & s_valid;
  assign w_line_end  = (r_col == LAST_COL);
  assign w_edge_col  = (r_col == 10'd0) | w_line_end;
  assign w_hold_done = (r_hold == HOLD_C);
  assign w_primed    = (r_row_in >= PRIME_LAST);
  assign w_more_rows = (r_row_in < LAST_ROW);

  // Frame sequencer: every output is a register updated alongside the state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= IDLE;
      r_col        <= '0;
      r_row_in     <= '0;
      r_hold       <= '0;
      r_to_read    <= 1'b0;
      r_s_ready    <= 1'b0;
      r_m_data     <= '0;
      r_m_valid    <= 1'b0;
      r_m_last     <= 1'b0;
      r_d_in       <= '0;
      r_wren       <= 1'b0;
      r_cursor     <= '0;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (frame_start) begin
            r_state   <= WRITE;
            r_busy    <= 1'b1;
            r_s_ready <= 1'b1;
            r_col     <= '0;
            r_row_in  <= '0;
          end
        end

        WRITE: begin
          // Held high through the edge after the last accept so the final
          // pixel of the line still lands in the RAM.
          r_wren <= 1'b1;
          if (w_s_accept) begin
            r_d_in   <= s_data;
            r_cursor <= r_col;
            if (w_line_end) begin
              r_col     <= '0;
              r_row_in  <= r_row_in + ROW_W'(1);
              r_s_ready <= 1'b0;
              r_to_read <= w_primed;
              r_state   <= SETTLE;
            end else begin
              r_col <= r_col + 10'd1;
            end
          end
        end

        SETTLE: begin
          // One low cycle on wren so the filter sees a fresh rising edge.
          r_wren <= 1'b0;
          if (r_to_read) begin
            r_state  <= READ;
            r_cursor <= r_col;
            r_hold   <= '0;
          end else begin
            r_state   <= WRITE;
            r_s_ready <= 1'b1;
          end
        end

        READ: begin
          if (w_edge_col) begin
            // Border columns have no full neighbourhood: emit black at once.
            r_m_data  <= 16'h0000;
            r_m_valid <= 1'b1;
            r_m_last  <= w_line_end;
            r_state   <= EMIT;
          end else if (w_hold_done && f_d_rdy) begin
            r_m_data  <= f_d_out;
            r_m_valid <= 1'b1;
            r_m_last  <= w_line_end;
            r_state   <= EMIT;
          end else if (!w_hold_done) begin
            r_hold <= r_hold + HOLD_W'(1);
          end
        end

        EMIT: begin
          if (m_ready) begin
            r_m_valid <= 1'b0;
            r_m_last  <= 1'b0;
            if (!w_line_end) begin
              r_col    <= r_col + 10'd1;
              r_cursor <= r_col + 10'd1;
              r_hold   <= '0;
              r_state  <= READ;
            end else if (w_more_rows) begin
              r_col     <= '0;
              r_to_read <= 1'b0;
              r_state   <= SETTLE;
            end else begin
              r_frame_done <= 1'b1;
              r_busy       <= 1'b0;
              r_state      <= IDLE;
            end
          end
        end

        default: r_state <= IDLE;
      endcase
    end
  end

  assign s_ready    = r_s_ready;
  assign m_data     = r_m_data;
  assign m_valid    = r_m_valid;
  assign m_last     = r_m_last;
  assign f_d_in     = r_d_in;
  assign f_wren     = r_wren;
  assign f_cursor   = r_cursor;
  assign busy       = r_busy;
  assign frame_done = r_frame_done;

`ifdef FILTER_SEQ_STATS_EN
  logic [31:0] r_stall_cycles;
  logic        w_stall;

  assign w_stall = (r_m_valid & ~m_ready) | ((r_state == WRITE) & ~s_valid);

  // Saturating count of downstream back-pressure and upstream starvation cycles.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stall_cycles <= '0;
    end else if ((r_state == IDLE) && frame_start) begin
      r_stall_cycles <= '0;
    end else if (w_stall && (r_stall_cycles != 32'hFFFF_FFFF)) begin
      r_stall_cycles <= r_stall_cycles + 32'd1;
    end
  end

  assign stall_cycles = r_stall_cycles;
`endif

endmodule

// File: tb/tb_filter_line_sequencer.sv
// Self-checking bench for filter_line_sequencer. A behavioural 3x3 filter
// emulation sits on the f_* side; expected outputs come from the raw input
// frame via a direct neighbourhood sum, independent of RAM row rotation.
module tb_filter_line_sequencer;

  localparam int BL    = 8;
  localparam int NR    = 5;
  localparam int HOLD  = 3;
  localparam int TOTAL = (NR - 2) * BL;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        frame_start = 1'b0;
  logic [15:0] s_data = 16'h0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [15:0] m_data;
  logic        m_valid;
  logic        m_ready = 1'b0;
  logic        m_last;
  logic [15:0] f_d_in;
  logic        f_wren;
  logic [9:0]  f_cursor;
  logic [15:0] f_d_out = 16'h0;
  logic        f_d_rdy = 1'b0;
  logic        busy;
  logic        frame_done;
`ifdef FILTER_SEQ_STATS_EN
  logic [31:0] stall_cycles;
`endif

  int checks = 0;
  int errors = 0;
  logic [15:0] in_pix [NR][BL];
  bit rdy_rand_en = 1'b0;

  filter_line_sequencer #(.BLOCK_LENGTH(BL), .ROWS(NR), .HOLD(HOLD)) dut (
    .clk(clk), .reset(rst), .frame_start(frame_start),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last),
    .f_d_in(f_d_in), .f_wren(f_wren), .f_cursor(f_cursor),
    .f_d_out(f_d_out), .f_d_rdy(f_d_rdy),
    .busy(busy), .frame_done(frame_done)
`ifdef FILTER_SEQ_STATS_EN
    , .stall_cycles(stall_cycles)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- filter emulation ----------------
  logic [15:0] fram [3][BL];
  int   fsel = 2;
  bit   fwren_q = 1'b0;
  logic [9:0] fcur_q = 10'd0;
  int   fstable = 0;

  function automatic logic [15:0] conv(input int c);
    int rows [3];
    int acc;
    int cc;
    rows[0] = (fsel + 1) % 3;
    rows[1] = (fsel + 2) % 3;
    rows[2] = fsel;
    acc = 0;
    for (int dy = 0; dy < 3; dy++)
      for (int dx = 0; dx < 3; dx++) begin
        cc = c + dx - 1;
        if (cc < 0) cc = 0;
        if (cc > BL - 1) cc = BL - 1;
        acc += (3 * dy + dx + 1) * int'(fram[rows[dy]][cc]);
      end
    return acc[15:0];
  endfunction

  // Row selector advances on each wren rising edge; output is only good
  // once the cursor has been steady and the ready flag is up.
  always @(posedge clk or posedge rst) begin
    bit rdy;
    if (rst) begin
      fsel = 2;
      fwren_q = 1'b0;
      fcur_q = 10'd0;
      fstable = 0;
      f_d_out <= 16'h0;
      f_d_rdy <= 1'b0;
    end else begin
      if (f_wren) begin
        if (!fwren_q) fsel = (fsel + 1) % 3;
        if (int'(f_cursor) < BL) fram[fsel][f_cursor] = f_d_in;
      end
      fwren_q = f_wren;
      if (f_cursor == fcur_q) begin
        if (fstable < 100) fstable++;
      end else begin
        fstable = 0;
      end
      fcur_q = f_cursor;
      rdy = (fstable >= 1) && (!rdy_rand_en || ($urandom_range(3) != 0));
      f_d_rdy <= rdy;
      f_d_out <= (fstable >= 2 && rdy) ? conv(int'(f_cursor)) : 16'hBAD0;
    end
  end

  // ---------------- reference ----------------
  // Output line k is centred on input line k+1; borders are black.
  function automatic logic [15:0] ref_pix(input int k, input int c);
    int acc;
    if (c == 0 || c == BL - 1) return 16'h0000;
    acc = 0;
    for (int dy = 0; dy < 3; dy++)
      for (int dx = 0; dx < 3; dx++)
        acc += (3 * dy + dx + 1) * int'(in_pix[k + dy][c + dx - 1]);
    return acc[15:0];
  endfunction

  task automatic fill_const(input logic [15:0] v);
    for (int r = 0; r < NR; r++)
      for (int c = 0; c < BL; c++) in_pix[r][c] = v;
  endtask

  task automatic fill_rand();
    for (int r = 0; r < NR; r++)
      for (int c = 0; c < BL; c++) in_pix[r][c] = 16'($urandom);
  endtask

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_s_ready"}, s_ready, 0);
    check({pfx, "_m_valid"}, m_valid, 0);
    check({pfx, "_m_last"}, m_last, 0);
    check({pfx, "_m_data"}, m_data, 0);
    check({pfx, "_f_wren"}, f_wren, 0);
    check({pfx, "_f_cursor"}, f_cursor, 0);
    check({pfx, "_f_d_in"}, f_d_in, 0);
    check({pfx, "_busy"}, busy, 0);
    check({pfx, "_frame_done"}, frame_done, 0);
  endtask

  // vmode: 0 always valid, 1 toggle, 2 random. rmode: 0 always ready, 1 random.
  task automatic run_frame(input string name, input int vmode, input int rmode,
                           input int stall_at, input int reset_at, input int bstart_at);
    int in_idx = 0, out_idx = 0, cyc = 0, done_cnt = 0;
    int stall_left = 0, low_run = 0, tail = 0, rel_cnt = -1, exp_stall = 0;
    bit prev_wren = 1'b0, prev_stalled = 1'b0, prev_mv = 1'b0, stall_used = 1'b0;
    logic [15:0] prev_data = 16'h0;
    logic prev_last = 1'b0;
    logic [9:0] prev_cur = 10'd0;

    @(negedge clk);
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    check("busy_after_start", busy, 1);

    while (cyc < 5000 && !(out_idx == TOTAL && done_cnt > 0 && tail >= 3)) begin
      if (out_idx == TOTAL) tail++;
      if (frame_done) begin
        done_cnt++;
        check("done_after_last", out_idx, TOTAL);
      end
      if (in_idx % BL != 0) check("wren_line_high", f_wren, 1);
      if (!f_wren) begin
        low_run++;
      end else begin
        if (!prev_wren && in_idx >= BL && in_idx < 3 * BL) check("wren_gap", low_run, 1);
        low_run = 0;
      end
      if (prev_stalled) begin
        check("hold_valid", m_valid, 1);
        check("hold_data", m_data, prev_data);
        check("hold_last", m_last, prev_last);
      end
      if (prev_mv && m_valid) check("cursor_steady", f_cursor, prev_cur);
      if (rel_cnt >= 0) begin
        rel_cnt++;
        if (m_valid) begin
          check("release_latency_ok", rel_cnt <= HOLD + 2, 1);
          rel_cnt = -1;
        end
      end

      if (reset_at >= 0 && out_idx == reset_at && !m_valid && busy) begin
        #1 rst = 1'b1;
        #1 check_reset_outputs("midreset");
        $display("%s: reset asserted after %0d outputs", name, out_idx);
        @(negedge clk);
        rst = 1'b0;
        return;
      end

      frame_start = (cyc == bstart_at);
      case (vmode)
        0: s_valid = 1'b1;
        1: s_valid = (cyc % 2 == 0);
        default: s_valid = ($urandom_range(9) < 7);
      endcase
      s_data = (in_idx < NR * BL) ? in_pix[in_idx / BL][in_idx % BL] : 16'h0;
      if (s_ready && s_valid) in_idx++;

      if (stall_left > 0) begin
        m_ready = 1'b0;
        stall_left--;
      end else if (!stall_used && stall_at >= 0 && out_idx == stall_at && m_valid) begin
        m_ready = 1'b0;
        stall_left = 9;
        stall_used = 1'b1;
      end else begin
        m_ready = (rmode == 0) ? 1'b1 : ($urandom_range(2) != 0);
      end

      if (m_valid && m_ready) begin
        $display("%s: out %0d line %0d col %0d data %04h last %0b", name, out_idx,
                 out_idx / BL, out_idx % BL, m_data, m_last);
        check("m_data", m_data, ref_pix(out_idx / BL, out_idx % BL));
        check("m_last", m_last, (out_idx % BL) == BL - 1);
        if (stall_used && out_idx == stall_at) rel_cnt = 0;
        out_idx++;
      end

      exp_stall += int'(s_ready && !s_valid) + int'(m_valid && !m_ready);
      prev_stalled = m_valid && !m_ready;
      prev_data = m_data;
      prev_last = m_last;
      prev_cur = f_cursor;
      prev_mv = m_valid;
      prev_wren = f_wren;
      cyc++;
      @(negedge clk);
    end
    frame_start = 1'b0;
    s_valid = 1'b0;
    m_ready = 1'b0;

    if (reset_at >= 0) check("reset_injected", out_idx, reset_at);
    check("outputs_all", out_idx, TOTAL);
    check("frame_done_once", done_cnt, 1);
    check("busy_end", busy, 0);
    check("inputs_all", in_idx, NR * BL);
`ifdef FILTER_SEQ_STATS_EN
    check("stall_cycles", stall_cycles, exp_stall);
`endif
    $display("%s: frame complete, %0d outputs, %0d cycles", name, out_idx, cyc);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    s_valid = 1'b1;
    @(negedge clk);
    check("idle_s_ready", s_ready, 0);
    check("idle_busy", busy, 0);
    s_valid = 1'b0;

    fill_const(16'h0841);
    rdy_rand_en = 1'b0;
    run_frame("const", 0, 0, -1, -1, -1);

    fill_rand();
    run_frame("toggle", 1, 0, -1, -1, 20);

    fill_rand();
    rdy_rand_en = 1'b1;
    run_frame("random", 2, 1, -1, -1, -1);

    fill_rand();
    rdy_rand_en = 1'b0;
    run_frame("stall", 0, 0, 9, -1, -1);

    fill_rand();
    run_frame("reset", 2, 0, -1, 10, -1);

    fill_rand();
    rdy_rand_en = 1'b1;
    run_frame("after_reset", 2, 1, -1, -1, -1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/filter_line_sequencer.md
# filter_line_sequencer

Streaming front/back end for the 3x3 line-buffer filter stage.
- Accepts a raster RGB565 pixel stream, writes each line into the filter's three row RAMs with a row-long write-enable, then sweeps the read cursor across the line.
- Collects the filtered pixel each time the filter raises its data-ready flag and emits it as a valid/ready output stream.
- Sits between the pixel source (DMA/camera reader) and the result writer in the SOPC image path.

## Interface
Parameters:
- BLOCK_LENGTH, 240, pixels per line; must match the filter instance.
- ROWS, 240, lines per frame (≥3).
- HOLD, 3, minimum cycles the cursor is held before a capture is allowed.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high; one clock, reset is asynchronous and active-high.
- frame_start  in  1  single-cycle pulse that starts a frame; ignored while busy=1.
- s_data  in  16  input pixel, RGB565.
- s_valid  in  1  input pixel valid.
- s_ready  out  1  sequencer accepts s_data this cycle.
- m_data  out  16  filtered pixel.
- m_valid  out  1  m_data valid; held until m_ready.
- m_ready  in  1  downstream accepts.
- m_last  out  1  marks column BLOCK_LENGTH-1 of an output line.
- f_d_in  out  16  to filter d_in.
- f_wren  out  1  to filter wren.
- f_cursor  out  10  to filter cursor.
- f_d_out  in  16  from filter d_out.
- f_d_rdy  in  1  from filter d_rdy.
- busy  out  1  frame in progress.
- frame_done  out  1  one-cycle pulse after the last output pixel handshakes.

## Operation
- States: IDLE, WRITE, SETTLE, READ, EMIT.
- IDLE → WRITE on frame_start. Clears col, row_in=0.
- WRITE:
  - f_wren=1 for every cycle of the state, so the filter's row selector advances exactly once per line.
  - s_ready=1.
  - On each s_valid&s_ready, register f_d_in=s_data and f_cursor=col, then col++.
  - During stalls the registered pair is rewritten unchanged.
  - After the BLOCK_LENGTH-th accept, row_in++ and col=0.
  - If row_in<3, stay in WRITE with f_wren dropped for one cycle between lines (SETTLE); otherwise → SETTLE → READ.
- SETTLE: f_wren=0, s_ready=0, one cycle; required so the filter sees a fresh rising edge of wren.
- READ:
  - f_cursor=col; hold counter counts up from 0 on each cursor change.
  - Capture happens when hold≥HOLD and f_d_rdy=1.
  - Columns 0 and BLOCK_LENGTH-1 bypass the wait and emit 0x0000.
  - On capture → EMIT.
- EMIT:
  - m_valid=1; m_data is the captured value; m_last=(col==BLOCK_LENGTH-1).
  - On m_ready: if col<BLOCK_LENGTH-1 then col++ → READ.
  - Else if row_in<ROWS then col=0 → SETTLE → WRITE.
  - Else pulse frame_done → IDLE.
- Output line k (0-based) is centred on input line k+1; a frame yields ROWS-2 output lines of BLOCK_LENGTH pixels.
- busy=1 in every state except IDLE.

## Timing
- Reset values: s_ready=0, m_valid=0, m_last=0, m_data=0, f_wren=0, f_cursor=0, f_d_in=0, busy=0, frame_done=0. State=IDLE.
- All outputs are registered; no combinational path from any input to any output.
- Input acceptance: 1 pixel/cycle in WRITE; the RAM write lands 2 edges after acceptance.
- Read latency per interior pixel: HOLD+1 cycles from the cursor change to m_valid, plus EMIT residency. Throughput ≤1 px / (HOLD+2) cycles.
- m_data and m_last are stable while m_valid&!m_ready.
- f_cursor never changes while m_valid=1.
- Reset mid-frame: immediate return to IDLE, partial line discarded, no frame_done. The filter shares the same reset, so the row selectors realign.
- frame_start during busy: no effect.
- s_valid while not in WRITE: s_ready=0, data not consumed.

## Configuration
- FILTER_SEQ_STATS_EN defined: adds output port stall_cycles [31:0]. It counts cycles with m_valid&!m_ready plus cycles in WRITE with !s_valid. It clears on an accepted frame_start, saturates at 0xFFFFFFFF, and resets to 0.
- Not defined: the port and counter are absent; all other behaviour is identical.

## Test plan
- BLOCK_LENGTH=8, ROWS=5, filter with default weights, every pixel 0x0841, m_ready=1 → 3 output lines of 8 pixels, all 0x0000, m_last on every 8th pixel, frame_done exactly once.
- Same setup, s_valid toggled 1/0 each cycle → f_wren stays high for the whole of each line, with exactly one low cycle between lines; output identical to the first test.
- Line 2 centre pixel 0x0020 (G=1), rest 0x0000 → output line 0 column 4 = 0x0080 (G=4); neighbours wrap per the filter's width truncation; column 0 and column 7 = 0x0000.
- m_ready low for 10 cycles while m_valid=1 → m_data, m_last and f_cursor held constant; next pixel follows within HOLD+2 cycles after release.
- reset asserted during READ of output line 1 → all outputs take their reset values in the same cycle. A new frame_start then produces a correct full frame.
- With FILTER_SEQ_STATS_EN, m_ready held low for 7 cycles once → stall_cycles=7 at frame_done, or 7 plus the number of s_valid gaps.
